// File: rtl/note_pkg.sv
// rtl/note_pkg.sv - shared types and note-word field layout for the note sequencer
package note_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, PLAY} state_t;

  localparam int HP_W    = 7;
  localparam int DUR_W   = 4;
  localparam int NOTE_W  = 11;
  localparam int HP_LSB  = 0;
  localparam int DUR_LSB = 7;

  localparam logic [DUR_W-1:0] END_DUR = '0;

  function automatic logic [HP_W-1:0] note_hp(input logic [NOTE_W-1:0] word);
    return word[HP_LSB +: HP_W];
  endfunction

  function automatic logic [DUR_W-1:0] note_dur(input logic [NOTE_W-1:0] word);
    return word[DUR_LSB +: DUR_W];
  endfunction

endpackage

// File: rtl/note_tick_prescaler.sv
// rtl/note_tick_prescaler.sv - restartable duration-unit prescaler, pulses tick every TICK_DIV enabled cycles
module note_tick_prescaler #(
  parameter int TICK_DIV = 2048
) (
  input  logic synth_clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

  logic [15:0] tick_ctr;

  assign tick = enable && (tick_ctr == TICK_LAST);

  always_ff @(posedge synth_clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_ctr <= '0;
    end else if (clear) begin
      tick_ctr <= '0;
    end else if (enable) begin
      tick_ctr <= tick ? 16'd0 : tick_ctr + 16'd1;
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// rtl/note_sequencer.sv - walks a note ROM and drives freq_synth hp/active; NOTE_SEQ_ARTIC_GAP_EN silences the last duration unit of each note
module note_sequencer
  import note_pkg::*;
#(
  parameter int ADDR_W   = 6,
  parameter int TICK_DIV = 2048
) (
  input  logic              synth_clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [NOTE_W-1:0] rom_data,
  output logic [HP_W-1:0]   hp,
  output logic              active,
  output logic              busy,
  output logic              note_strobe
);

`ifdef NOTE_SEQ_ARTIC_GAP_EN
  localparam bit ARTIC_GAP = 1'b1;
`else
  localparam bit ARTIC_GAP = 1'b0;
`endif

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [HP_W-1:0]   hp_nxt;
  logic              active_nxt;
  logic [DUR_W-1:0]  dur_ctr, dur_nxt;
  logic              strobe_nxt;
  logic              tick;
  logic [HP_W-1:0]   word_hp;
  logic [DUR_W-1:0]  word_dur;

  assign word_hp  = note_hp(rom_data);
  assign word_dur = note_dur(rom_data);
  assign busy     = (state != IDLE);

  note_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .synth_clk (synth_clk),
    .rst_n     (rst_n),
    .clear     (state == LOAD),
    .enable    (state == PLAY),
    .tick      (tick)
  );

  always_ff @(posedge synth_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rom_addr    <= '0;
      hp          <= '0;
      active      <= 1'b0;
      dur_ctr     <= '0;
      note_strobe <= 1'b0;
    end else begin
      state       <= state_nxt;
      rom_addr    <= addr_nxt;
      hp          <= hp_nxt;
      active      <= active_nxt;
      dur_ctr     <= dur_nxt;
      note_strobe <= strobe_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    addr_nxt   = rom_addr;
    hp_nxt     = hp;
    active_nxt = active;
    dur_nxt    = dur_ctr;
    strobe_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          addr_nxt  = '0;
          state_nxt = FETCH;
        end
      end
      FETCH: state_nxt = LOAD;
      LOAD: begin
        if (word_dur == END_DUR) begin
          // An end marker at address 0 always finishes, so an empty song cannot spin.
          if (loop_en && rom_addr != '0) begin
            addr_nxt  = '0;
            state_nxt = FETCH;
          end else begin
            hp_nxt     = '0;
            active_nxt = 1'b0;
            state_nxt  = IDLE;
          end
        end else begin
          hp_nxt     = word_hp;
          active_nxt = (word_hp != '0) && !(ARTIC_GAP && word_dur == DUR_W'(1));
          dur_nxt    = word_dur;
          strobe_nxt = 1'b1;
          addr_nxt   = rom_addr + ADDR_W'(1);
          state_nxt  = PLAY;
        end
      end
      PLAY: begin
        if (tick) begin
          dur_nxt = dur_ctr - DUR_W'(1);
          if (dur_ctr == DUR_W'(1)) begin
            state_nxt = FETCH;
          end else if (ARTIC_GAP && dur_ctr == DUR_W'(2)) begin
            active_nxt = 1'b0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Stop overrides every other transition out of a busy state.
    if (state != IDLE && stop) begin
      state_nxt  = IDLE;
      addr_nxt   = '0;
      hp_nxt     = '0;
      active_nxt = 1'b0;
      strobe_nxt = 1'b0;
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// tb/tb_note_sequencer.sv - self-checking bench for note_sequencer against a song-level trace model
module tb_note_sequencer;

  localparam int ADDR_W   = 6;
  localparam int TICK_DIV = 4;
  localparam int DEPTH    = 64;

  logic              synth_clk = 1'b0;
  logic              rst_n     = 1'b0;
  logic              start     = 1'b0;
  logic              stop      = 1'b0;
  logic              loop_en   = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [10:0]       rom_data;
  logic [6:0]        hp;
  logic              active;
  logic              busy;
  logic              note_strobe;

  logic [10:0] rom [DEPTH];

  int vectors     = 0;
  int miscompares = 0;
  int strobes_seen;
  logic obs_act_q [$];

  typedef struct packed {
    logic [6:0] hp;
    logic       act;
    logic       busy;
    logic       strobe;
    logic       chk_addr;
    logic [5:0] addr;
  } exp_t;

  exp_t exp_q [$];

  note_sequencer #(.ADDR_W(ADDR_W), .TICK_DIV(TICK_DIV)) dut (
    .synth_clk   (synth_clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .loop_en     (loop_en),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .hp          (hp),
    .active      (active),
    .busy        (busy),
    .note_strobe (note_strobe)
  );

  always #5 synth_clk = ~synth_clk;

  always @(posedge synth_clk) rom_data <= rom[rom_addr];

  function automatic logic [10:0] note(input int d, input int h);
    return {d[3:0], h[6:0]};
  endfunction

  function automatic exp_t mk(input int h, input bit a, input bit b, input bit s, input bit c, input int ad);
    exp_t e;
    e.hp = h[6:0]; e.act = a; e.busy = b; e.strobe = s; e.chk_addr = c; e.addr = ad[5:0];
    return e;
  endfunction

  // Expected per-cycle outputs, starting with the cycle after start is sampled.
  task automatic build_trace(input bit lp, input int n);
    int a, d, h, cur_hp;
    bit cur_act, act, done;
    exp_q.delete();
    a = 0; cur_hp = 0; cur_act = 1'b0; done = 1'b0;
    exp_q.push_back(mk(0, 0, 1, 0, 1, 0));
    exp_q.push_back(mk(0, 0, 1, 0, 1, 0));
    while (exp_q.size() < n) begin
      d = int'(rom[a][10:7]);
      h = int'(rom[a][6:0]);
      if (done) begin
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
      end else if (d == 0) begin
        if (lp && a != 0) begin
          a = 0;
`ifdef NOTE_SEQ_ARTIC_GAP_EN
          cur_act = 1'b0;
`endif
          exp_q.push_back(mk(cur_hp, cur_act, 1, 0, 1, 0));
          exp_q.push_back(mk(cur_hp, cur_act, 1, 0, 1, 0));
        end else begin
          done = 1'b1;
        end
      end else begin
        for (int k = 0; k < d * TICK_DIV + 2; k++) begin
          act = (h != 0);
`ifdef NOTE_SEQ_ARTIC_GAP_EN
          if (k >= (d - 1) * TICK_DIV) act = 1'b0;
`endif
          exp_q.push_back(mk(h, act, 1, k == 0, 1, (a + 1) % DEPTH));
        end
        cur_hp = h; cur_act = (h != 0);
        a = (a + 1) % DEPTH;
      end
    end
  endtask

  task automatic run_check(input string name, input int n);
    exp_t e;
    strobes_seen = 0;
    obs_act_q.delete();
    for (int i = 0; i < n; i++) begin
      @(posedge synth_clk); #1;
      if (i == 0) start = 1'b0;
      e = exp_q[i];
      vectors++;
      if (note_strobe === 1'b1) strobes_seen++;
      obs_act_q.push_back(active);
      if ({hp, active, busy, note_strobe} !== {e.hp, e.act, e.busy, e.strobe} ||
          (e.chk_addr && rom_addr !== e.addr)) begin
        miscompares++;
        $display("FAIL %s cycle %0d: hp=%0d active=%b busy=%b strobe=%b addr=%0d, expected hp=%0d active=%b busy=%b strobe=%b addr=%0d",
                 name, i, hp, active, busy, note_strobe, rom_addr, e.hp, e.act, e.busy, e.strobe, e.addr);
      end
    end
  endtask

  task automatic stop_check(input string name);
    stop = 1'b1;
    @(posedge synth_clk); #1;
    vectors++;
    if ({hp, active, busy, note_strobe} !== 10'b0) begin
      miscompares++;
      $display("FAIL %s: hp=%0d active=%b busy=%b strobe=%b, expected all 0", name, hp, active, busy, note_strobe);
    end
    stop = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    vectors++;
    if ({hp, active, busy, note_strobe, rom_addr} !== 16'b0) begin
      miscompares++;
      $display("FAIL reset: hp=%0d active=%b busy=%b strobe=%b addr=%0d, expected all 0", hp, active, busy, note_strobe, rom_addr);
    end
    @(negedge synth_clk); rst_n = 1'b1;
  endtask

  task automatic load_basic;
    for (int i = 0; i < DEPTH; i++) rom[i] = note(0, $urandom_range(0, 127));
    rom[0] = note(3, 10);
    rom[1] = note(2, 0);
    rom[2] = note(0, $urandom_range(0, 127));
  endtask

  task automatic test_basic;
    load_basic(); loop_en = 1'b0;
    @(negedge synth_clk); start = 1'b1;
    build_trace(1'b0, 2 + 14 + 10 + 4);
    run_check("basic", 2 + 14 + 10 + 4);
    vectors++;
    if (strobes_seen != 2) begin
      miscompares++;
      $display("FAIL basic_strobes: saw %0d, expected 2", strobes_seen);
    end
  endtask

  task automatic test_loop;
    load_basic(); loop_en = 1'b1;
    @(negedge synth_clk); start = 1'b1;
    build_trace(1'b1, 78);
    run_check("loop", 78);
    vectors++;
    if (strobes_seen != 6) begin
      miscompares++;
      $display("FAIL loop_strobes: saw %0d, expected 6", strobes_seen);
    end
    stop_check("loop_stop");
  endtask

  task automatic test_empty;
    rom[0] = note(0, 33); loop_en = 1'b1;
    @(negedge synth_clk); start = 1'b1;
    build_trace(1'b1, 6);
    run_check("empty", 6);
    vectors++;
    if (strobes_seen != 0) begin
      miscompares++;
      $display("FAIL empty_strobes: saw %0d, expected 0", strobes_seen);
    end
  endtask

  task automatic test_stop;
    load_basic(); loop_en = 1'b0;
    @(negedge synth_clk); start = 1'b1;
    build_trace(1'b0, 7);
    run_check("stop_pre", 7);
    stop_check("stop_mid");
    vectors++;
    if (rom_addr !== '0) begin
      miscompares++;
      $display("FAIL stop_addr: addr=%0d, expected 0", rom_addr);
    end
    @(negedge synth_clk); start = 1'b1; stop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge synth_clk); #1;
      vectors++;
      if (busy !== 1'b0) begin
        miscompares++;
        $display("FAIL start_stop_idle cycle %0d: busy=%b, expected 0", i, busy);
      end
    end
    @(negedge synth_clk); stop = 1'b0;
    build_trace(1'b0, 30);
    run_check("replay", 30);
  endtask

  task automatic test_async_reset;
    load_basic(); loop_en = 1'b0;
    @(negedge synth_clk); start = 1'b1;
    build_trace(1'b0, 8);
    run_check("areset_pre", 8);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({hp, active, busy, rom_addr} !== 15'b0) begin
      miscompares++;
      $display("FAIL async_reset: hp=%0d active=%b busy=%b addr=%0d, expected all 0", hp, active, busy, rom_addr);
    end
    repeat (2) @(posedge synth_clk);
    @(negedge synth_clk); rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge synth_clk); #1;
      vectors++;
      if ({hp, active, busy, note_strobe} !== 10'b0) begin
        miscompares++;
        $display("FAIL post_reset_idle cycle %0d: hp=%0d active=%b busy=%b strobe=%b, expected all 0", i, hp, active, busy, note_strobe);
      end
    end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < DEPTH; i++) rom[i] = note(1, $urandom_range(1, 127));
    loop_en = 1'b0;
    @(negedge synth_clk); start = 1'b1;
    build_trace(1'b0, 2 + 66 * (TICK_DIV + 2));
    run_check("wrap", 2 + 66 * (TICK_DIV + 2));
    stop_check("wrap_stop");
  endtask

  task automatic test_artic;
    int run, best;
    bit seen_one;
    for (int i = 0; i < DEPTH; i++) rom[i] = note(0, 0);
    rom[0] = note(2, 20);
    rom[1] = note(2, 20);
    loop_en = 1'b0;
    @(negedge synth_clk); start = 1'b1;
    build_trace(1'b0, 26);
    run_check("artic", 26);
    run = 0; best = 0; seen_one = 1'b0;
    foreach (obs_act_q[i]) begin
      if (obs_act_q[i] === 1'b1) begin
        if (seen_one && run > best) best = run;
        seen_one = 1'b1; run = 0;
      end else begin
        run++;
      end
    end
    vectors++;
`ifdef NOTE_SEQ_ARTIC_GAP_EN
    if (best != TICK_DIV + 2) begin
`else
    if (best != 0) begin
`endif
      miscompares++;
      $display("FAIL artic_gap: silent run between notes %0d cycles", best);
    end
  endtask

  task automatic test_random;
    int len, n;
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < DEPTH; i++) rom[i] = note($urandom_range(0, 15), $urandom_range(0, 127));
      len = $urandom_range(1, 6);
      for (int a = 0; a < len; a++)
        rom[a] = note($urandom_range(1, 3), ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 127));
      rom[len] = note(0, $urandom_range(0, 127));
      loop_en = 1'($urandom_range(0, 1));
      n = $urandom_range(30, 150);
      @(negedge synth_clk); start = 1'b1;
      build_trace(loop_en, n);
      run_check($sformatf("random%0d", it), n);
      stop_check($sformatf("random%0d_stop", it));
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) rom[i] = '0;
    test_reset();
    test_basic();
    test_loop();
    test_empty();
    test_stop();
    test_async_reset();
    test_wrap();
    test_artic();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
